// File: rtl/dmem_lsu.sv
`default_nettype none
// dmem_lsu -- RV32I load/store unit driving a data memory with one-cycle registered reads.
// Optional feature: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses. Rev 1.0
module dmem_lsu #(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [2:0]                 req_funct3_i,
  input  logic [31:0]                req_addr_i,
  input  logic [31:0]                req_wdata_i,
  output logic                       rsp_valid_o,
  output logic [31:0]                rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [DMEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic                       mem_read_o,
  output logic                       mem_write_o,
  output logic [3:0]                 mem_size_o,
  output logic [31:0]                mem_din_o,
  input  logic [31:0]                mem_dout_i
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t                     state;
  logic                       we_q;
  logic [2:0]                 funct3_q;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                wdata_q;

  logic                       legal_f3;
  logic                       reject;
  logic [DMEM_ADDR_WIDTH-1:0] acc_addr;
  logic                       unused_addr_hi;

  // Upper address bits are dropped so accesses wrap inside the memory.
  assign unused_addr_hi = ^req_addr_i[31:DMEM_ADDR_WIDTH];

  always_comb begin
    if (req_we_i)
      legal_f3 = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                 (req_funct3_i == 3'b010);
    else
      legal_f3 = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
                 (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
                 (req_funct3_i == 3'b101);
    acc_addr = req_addr_i[DMEM_ADDR_WIDTH-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    reject = !legal_f3 ||
             ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
             ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
    reject = !legal_f3;
    if (req_funct3_i[1:0] == 2'b01)
      acc_addr[0] = 1'b0;
    else if (req_funct3_i[1:0] == 2'b10)
      acc_addr[1:0] = 2'b00;
`endif
  end

  logic [3:0]  st_be;
  logic [31:0] st_data;

  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        st_be   = 4'b0011 << addr_q[1:0];
        st_data = {2{wdata_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_dout_i[7:0];
      2'b01:   ld_byte = mem_dout_i[15:8];
      2'b10:   ld_byte = mem_dout_i[23:16];
      default: ld_byte = mem_dout_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = mem_dout_i;
    endcase
  end

  // Strobes are gated by reset so an in-flight store never commits on a reset edge.
  assign req_ready_o = (state == IDLE) && !rst_i;
  assign mem_addr_o  = addr_q;
  assign mem_read_o  = (state == ACCESS) && !we_q && !rst_i;
  assign mem_write_o = (state == ACCESS) && we_q && !rst_i;
  assign mem_size_o  = ((state == ACCESS) && we_q) ? st_be : 4'b0000;
  assign mem_din_o   = st_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= 32'h0;
          if (req_valid_i) begin
            we_q     <= req_we_i;
            funct3_q <= req_funct3_i;
            addr_q   <= acc_addr;
            wdata_q  <= req_wdata_i;
            if (reject) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (we_q) begin
            state       <= RESP;
            rsp_valid_o <= 1'b1;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_rdata_o <= ld_data;
          rsp_valid_o <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          rsp_valid_o <= 1'b0;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= 32'h0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu.sv
`default_nettype none
// tb_dmem_lsu -- table-driven bench with a response scoreboard and a behavioural data memory.
module tb_dmem_lsu;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [11:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_size;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = 32'h0;

  dmem_lsu #(.DMEM_ADDR_WIDTH(12)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_addr_o(mem_addr), .mem_read_o(mem_read), .mem_write_o(mem_write),
    .mem_size_o(mem_size), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte-enabled memory with one-cycle registered read.
  logic        mem_clr = 1'b1;
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_size[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
      if (mem_read) mem_dout <= mem[mem_addr[11:2]];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] maddr;
    logic [3:0]  size;
    logic [31:0] din;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          idx;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                              input logic [11:0] maddr, input logic [3:0] size, input logic [31:0] din);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.err = err;
    v.rdata = rdata; v.maddr = maddr; v.size = size; v.din = din;
    return v;
  endfunction

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                     input logic [11:0] maddr, input logic [3:0] size, input logic [31:0] din);
    vecs.push_back(mk(we, f3, addr, wdata, err, rdata, maddr, size, din));
  endtask

  // Scoreboard: every response must match the oldest outstanding expectation, on its cycle.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk($sformatf("v%0d_err", e.idx), 32'(rsp_err), 32'(e.err));
        chk($sformatf("v%0d_rdata", e.idx), rsp_rdata, e.rdata);
        chk($sformatf("v%0d_rsp_cycle", e.idx), 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called and returns at a negedge; issues one request and checks strobes and turnaround.
  task automatic do_req(input vec_t v, input int idx);
    int n;
    int acc;
    int lat;
    exp_t e;
    lat = v.err ? 1 : (v.we ? 2 : 3);
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_ready", idx), 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    e.err = v.err; e.rdata = v.rdata; e.cyc = acc + lat - 1; e.idx = idx;
    exp_q.push_back(e);
    @(negedge clk);
    if (v.err) begin
      chk($sformatf("v%0d_rej_strobes", idx), {30'h0, mem_read, mem_write}, 32'h0);
    end else begin
      chk($sformatf("v%0d_mem_addr", idx), 32'(mem_addr), 32'(v.maddr));
      chk($sformatf("v%0d_mem_rd_wr", idx), {30'h0, mem_read, mem_write}, v.we ? 32'h1 : 32'h2);
      chk($sformatf("v%0d_mem_size", idx), 32'(mem_size), 32'(v.size));
      if (v.we) chk($sformatf("v%0d_mem_din", idx), mem_din, v.din);
      @(negedge clk);
      chk($sformatf("v%0d_idle_strobes", idx), {26'h0, mem_size, mem_read, mem_write}, 32'h0);
    end
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk($sformatf("v%0d_next_accept", idx), 32'(cyc - acc), 32'(lat));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    //   we f3    addr          wdata         err rdata         maddr   size    din
    add(1, F_W,   32'h10,       32'hDEADBEEF, 0, 32'h0,        12'h010, 4'hF, 32'hDEADBEEF);
    add(0, F_W,   32'h10,       32'h0,        0, 32'hDEADBEEF, 12'h010, 4'h0, 32'h0);
    add(1, F_W,   32'h00,       32'h12345678, 0, 32'h0,        12'h000, 4'hF, 32'h12345678);
    add(1, F_B,   32'h13,       32'h000000A5, 0, 32'h0,        12'h013, 4'h8, 32'hA5A5A5A5);
    add(0, F_B,   32'h13,       32'h0,        0, 32'hFFFFFFA5, 12'h013, 4'h0, 32'h0);
    add(0, F_BU,  32'h13,       32'h0,        0, 32'h000000A5, 12'h013, 4'h0, 32'h0);
    add(0, F_W,   32'h10,       32'h0,        0, 32'hA5ADBEEF, 12'h010, 4'h0, 32'h0);
    add(0, F_B,   32'h11,       32'h0,        0, 32'hFFFFFFBE, 12'h011, 4'h0, 32'h0);
    add(0, F_BU,  32'h12,       32'h0,        0, 32'h000000AD, 12'h012, 4'h0, 32'h0);
    add(0, F_H,   32'h10,       32'h0,        0, 32'hFFFFBEEF, 12'h010, 4'h0, 32'h0);
    add(0, F_HU,  32'h10,       32'h0,        0, 32'h0000BEEF, 12'h010, 4'h0, 32'h0);
    add(1, F_H,   32'h22,       32'h00008001, 0, 32'h0,        12'h022, 4'hC, 32'h80018001);
    add(0, F_H,   32'h22,       32'h0,        0, 32'hFFFF8001, 12'h022, 4'h0, 32'h0);
    add(0, F_HU,  32'h22,       32'h0,        0, 32'h00008001, 12'h022, 4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(0, F_W,   32'h02,       32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
`else
    add(0, F_W,   32'h02,       32'h0,        0, 32'h12345678, 12'h000, 4'h0, 32'h0);
`endif
    add(0, 3'b111, 32'h10,      32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(1, 3'b011, 32'h10,      32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(0, 3'b110, 32'h10,      32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(1, 3'b111, 32'h10,      32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(0, F_W,   32'h10,       32'h0,        0, 32'hA5ADBEEF, 12'h010, 4'h0, 32'h0);
    add(1, F_W,   32'hFFFFF044, 32'hCAFEF00D, 0, 32'h0,        12'h044, 4'hF, 32'hCAFEF00D);
    add(0, F_W,   32'h00001044, 32'h0,        0, 32'hCAFEF00D, 12'h044, 4'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    add(1, F_H,   32'h45,       32'h00001234, 1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(0, F_W,   32'h44,       32'h0,        0, 32'hCAFEF00D, 12'h044, 4'h0, 32'h0);
    add(0, F_H,   32'h47,       32'h0,        1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(1, F_W,   32'h16,       32'h55555555, 1, 32'h0,        12'h000, 4'h0, 32'h0);
    add(0, F_W,   32'h14,       32'h0,        0, 32'h00000000, 12'h014, 4'h0, 32'h0);
`else
    add(1, F_H,   32'h45,       32'h00001234, 0, 32'h0,        12'h044, 4'h3, 32'h12341234);
    add(0, F_W,   32'h44,       32'h0,        0, 32'hCAFE1234, 12'h044, 4'h0, 32'h0);
    add(0, F_H,   32'h47,       32'h0,        0, 32'hFFFFCAFE, 12'h046, 4'h0, 32'h0);
    add(1, F_W,   32'h16,       32'h55555555, 0, 32'h0,        12'h014, 4'hF, 32'h55555555);
    add(0, F_W,   32'h14,       32'h0,        0, 32'h55555555, 12'h014, 4'h0, 32'h0);
`endif
    add(0, F_HU,  32'h46,       32'h0,        0, 32'h0000CAFE, 12'h046, 4'h0, 32'h0);
    add(0, F_B,   32'h46,       32'h0,        0, 32'hFFFFFFFE, 12'h046, 4'h0, 32'h0);
    add(0, F_W,   32'h80,       32'h0,        0, 32'h00000000, 12'h080, 4'h0, 32'h0);

    // Reset with a store held on the request port: nothing may be accepted or written.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h80; req_wdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'h1);

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i], i);

    // Reset asserted while a store sits in ACCESS must suppress the write.
    do_req(mk(1, F_W, 32'h30, 32'h11111111, 0, 32'h0, 12'h030, 4'hF, 32'h11111111), 100);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F_W; req_addr = 32'h30; req_wdata = 32'h22222222;
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_write", 32'(mem_write), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h1);
    do_req(mk(0, F_W, 32'h30, 32'h0, 0, 32'h11111111, 12'h030, 4'h0, 32'h0), 101);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
